// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: instruction codes, IR sizing and TAP controller state encoding.
package jtag_pkg;

   localparam int unsigned IR_WIDTH = 4;

   localparam logic [IR_WIDTH-1:0] IR_IDCODE  = 4'b0001;
   localparam logic [IR_WIDTH-1:0] IR_USER    = 4'b0010;
   localparam logic [IR_WIDTH-1:0] IR_BYPASS  = 4'b1111;
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101;

   typedef enum logic [3:0] {
      TAP_TEST_LOGIC_RESET,
      TAP_RUN_TEST_IDLE,
      TAP_SELECT_DR_SCAN,
      TAP_CAPTURE_DR,
      TAP_SHIFT_DR,
      TAP_EXIT1_DR,
      TAP_PAUSE_DR,
      TAP_EXIT2_DR,
      TAP_UPDATE_DR,
      TAP_SELECT_IR_SCAN,
      TAP_CAPTURE_IR,
      TAP_SHIFT_IR,
      TAP_EXIT1_IR,
      TAP_PAUSE_IR,
      TAP_EXIT2_IR,
      TAP_UPDATE_IR
   } tap_state_e;

   typedef enum logic [1:0] {
      SEL_BYPASS,
      SEL_IDCODE,
      SEL_USER
   } dr_sel_e;

endpackage

// File: rtl/tap_shift_reg.sv
// Generic capture/shift chain: parallel load has precedence over right shift, both gated by enable.
module tap_shift_reg #(
   parameter int unsigned      WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             internal_clk,
   input  logic             tap_rstn,
   input  logic             enable,
   input  logic             capture,
   input  logic             shift,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             serial_in,
   output logic [WIDTH-1:0] parallel_out
);

   always_ff @(posedge internal_clk or negedge tap_rstn) begin
      if (!tap_rstn) begin
         parallel_out <= RESET_VALUE;
      end else if (enable) begin
         if (capture) begin
            parallel_out <= parallel_in;
         end else if (shift) begin
            parallel_out <= {serial_in, parallel_out[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/tap_data_path.sv
// JTAG TAP data path: instruction register plus IDCODE, BYPASS and USER data chains with TDO mux.
module tap_data_path #(
   parameter int unsigned             IR_WIDTH      = jtag_pkg::IR_WIDTH,
   parameter int unsigned             USER_DR_WIDTH = 32,
   parameter logic [31:0]             IDCODE_VALUE  = 32'h1000_0001
) (
   input  logic                     internal_clk,
   input  logic                     tap_rstn,
   input  logic                     tap_clk_enable,
   input  logic                     tap_tdi,
   input  logic                     tap_test_logic_reset,
   input  logic                     tap_capture_ir,
   input  logic                     tap_shift_ir,
   input  logic                     tap_update_ir,
   input  logic                     tap_capture_dr,
   input  logic                     tap_shift_dr,
   input  logic                     tap_update_dr,
   input  logic [USER_DR_WIDTH-1:0] user_dr_capture_data,
   output logic                     tap_tdo,
   output logic                     tap_tdo_en,
   output logic [IR_WIDTH-1:0]      ir_value,
   output logic [USER_DR_WIDTH-1:0] user_dr_update_data,
   output logic                     user_dr_update_pulse
);

   import jtag_pkg::*;

   localparam logic [IR_WIDTH-1:0] IDCODE_INSTR  = IR_WIDTH'(IR_IDCODE);
   localparam logic [IR_WIDTH-1:0] USER_INSTR    = IR_WIDTH'(IR_USER);
   localparam logic [IR_WIDTH-1:0] CAPTURE_INSTR = IR_WIDTH'(IR_CAPTURE);

   logic [IR_WIDTH-1:0]      ir_chain;
   logic [31:0]              idcode_chain;
   logic [USER_DR_WIDTH-1:0] user_chain;
   logic                     bypass_bit;
   logic                     idcode_unused;
   dr_sel_e                  dr_sel;

   // Strobe qualification: test-logic-reset beats everything, then capture > shift > update.
   logic ir_capture, ir_update;
   logic dr_capture, dr_shift, dr_update;

   assign ir_capture = tap_capture_ir | tap_test_logic_reset;
   assign ir_update  = tap_update_ir & ~tap_capture_ir & ~tap_shift_ir & ~tap_test_logic_reset;
   assign dr_capture = tap_capture_dr & ~tap_test_logic_reset;
   assign dr_shift   = tap_shift_dr & ~tap_capture_dr & ~tap_test_logic_reset;
   assign dr_update  = tap_update_dr & ~tap_shift_dr & ~tap_capture_dr & ~tap_test_logic_reset;

   always_comb begin
      dr_sel = SEL_BYPASS;
      if (ir_value == IDCODE_INSTR) begin
         dr_sel = SEL_IDCODE;
      end else if (ir_value == USER_INSTR) begin
         dr_sel = SEL_USER;
      end
   end

   tap_shift_reg #(.WIDTH(IR_WIDTH), .RESET_VALUE(CAPTURE_INSTR)) u_ir_chain (
      .internal_clk (internal_clk),
      .tap_rstn     (tap_rstn),
      .enable       (tap_clk_enable),
      .capture      (ir_capture),
      .shift        (tap_shift_ir),
      .parallel_in  (CAPTURE_INSTR),
      .serial_in    (tap_tdi),
      .parallel_out (ir_chain)
   );

   tap_shift_reg #(.WIDTH(32)) u_idcode_chain (
      .internal_clk (internal_clk),
      .tap_rstn     (tap_rstn),
      .enable       (tap_clk_enable),
      .capture      (dr_capture & (dr_sel == SEL_IDCODE)),
      .shift        (dr_shift & (dr_sel == SEL_IDCODE)),
      .parallel_in  (IDCODE_VALUE),
      .serial_in    (tap_tdi),
      .parallel_out (idcode_chain)
   );

   tap_shift_reg #(.WIDTH(USER_DR_WIDTH)) u_user_chain (
      .internal_clk (internal_clk),
      .tap_rstn     (tap_rstn),
      .enable       (tap_clk_enable),
      .capture      (dr_capture & (dr_sel == SEL_USER)),
      .shift        (dr_shift & (dr_sel == SEL_USER)),
      .parallel_in  (user_dr_capture_data),
      .serial_in    (tap_tdi),
      .parallel_out (user_chain)
   );

   // Only bit 0 of the IDCODE chain is ever observed.
   assign idcode_unused = ^idcode_chain[31:1];

   always_ff @(posedge internal_clk or negedge tap_rstn) begin
      if (!tap_rstn) begin
         bypass_bit <= 1'b0;
      end else if (tap_clk_enable && dr_sel == SEL_BYPASS) begin
         if (dr_capture) begin
            bypass_bit <= 1'b0;
         end else if (dr_shift) begin
            bypass_bit <= tap_tdi;
         end
      end
   end

   always_ff @(posedge internal_clk or negedge tap_rstn) begin
      if (!tap_rstn) begin
         ir_value <= IDCODE_INSTR;
      end else if (tap_clk_enable) begin
         if (tap_test_logic_reset) begin
            ir_value <= IDCODE_INSTR;
         end else if (ir_update) begin
            ir_value <= ir_chain;
         end
      end
   end

   // Pulse lasts one internal_clk cycle regardless of the TCK-rate qualifier.
   always_ff @(posedge internal_clk or negedge tap_rstn) begin
      if (!tap_rstn) begin
         user_dr_update_data  <= '0;
         user_dr_update_pulse <= 1'b0;
      end else begin
         user_dr_update_pulse <= tap_clk_enable & dr_update & (dr_sel == SEL_USER);
         if (tap_clk_enable && dr_update && dr_sel == SEL_USER) begin
            user_dr_update_data <= user_chain;
         end
      end
   end

   always_comb begin
      tap_tdo = 1'b0;
      if (tap_shift_ir) begin
         tap_tdo = ir_chain[0];
      end else if (tap_shift_dr) begin
         case (dr_sel)
            SEL_IDCODE: tap_tdo = idcode_chain[0];
            SEL_USER:   tap_tdo = user_chain[0];
            default:    tap_tdo = bypass_bit;
         endcase
      end
   end

   assign tap_tdo_en = tap_shift_ir | tap_shift_dr;

endmodule
